// File: rtl/addsub_4bit.sv
// addsub_4bit: 4-bit two's-complement adder/subtractor built as a ripple chain
// of full adders. Provides a combinational result with signed overflow, and
// registered copies of both. A sticky flag remembers any registered overflow
// until the next reset.
module addsub_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       sub,
    output logic [3:0] Sum,
    output logic       Ovfl,
    output logic [3:0] Sum_q,
    output logic       Ovfl_q,
    output logic       Ovfl_sticky
);

    localparam int unsigned W = 4;

    logic [W-1:0] bx;
    logic [W:0]   carry;
    logic [W-1:0] sum_d;
    logic         ovfl_d;
    logic         sticky_d;

    // Ripple-carry chain; subtraction inverts B and injects sub as carry-in
    always_comb begin
        bx       = B ^ {W{sub}};
        carry    = '0;
        carry[0] = sub;
        sum_d    = '0;
        for (int i = 0; i < int'(W); i++) begin
            sum_d[i]     = A[i] ^ bx[i] ^ carry[i];
            carry[i + 1] = (A[i] & bx[i]) | (carry[i] & (A[i] ^ bx[i]));
        end
        // Signed overflow: carry into and out of the sign bit disagree
        ovfl_d   = carry[W] ^ carry[W-1];
        sticky_d = Ovfl_sticky | ovfl_d;
    end

    assign Sum  = sum_d;
    assign Ovfl = ovfl_d;

    // Pipeline registers; reset wins over a same-cycle overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum_q       <= '0;
            Ovfl_q      <= 1'b0;
            Ovfl_sticky <= 1'b0;
        end else begin
            Sum_q       <= sum_d;
            Ovfl_q      <= ovfl_d;
            Ovfl_sticky <= sticky_d;
        end
    end

endmodule

// File: tb/tb_addsub_4bit.sv
// Self-checking bench for addsub_4bit: directed spec vectors, exhaustive
// combinational sweep, registered path / reset behaviour and a randomized run
// against an integer-arithmetic reference model.
module tb_addsub_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       sub;
    logic [3:0] Sum;
    logic       Ovfl;
    logic [3:0] Sum_q;
    logic       Ovfl_q;
    logic       Ovfl_sticky;

    int checks = 0;
    int errors = 0;

    // reference register state
    logic [3:0] m_sum_q;
    logic       m_ovfl_q;
    logic       m_sticky;

    addsub_4bit dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .sub        (sub),
        .Sum        (Sum),
        .Ovfl       (Ovfl),
        .Sum_q      (Sum_q),
        .Ovfl_q     (Ovfl_q),
        .Ovfl_sticky(Ovfl_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // True signed result of A +/- B as a plain integer
    function automatic int ref_result(input logic [3:0] a, input logic [3:0] b, input logic s);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        return s ? (ia - ib) : (ia + ib);
    endfunction

    function automatic logic [3:0] ref_sum(input logic [3:0] a, input logic [3:0] b, input logic s);
        int r;
        r = ref_result(a, b, s);
        return 4'((r + 16) % 16);
    endfunction

    function automatic logic ref_ovfl(input logic [3:0] a, input logic [3:0] b, input logic s);
        int r;
        r = ref_result(a, b, s);
        return (r > 7) || (r < -8);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; A = 4'h7; B = 4'h1; sub = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({Sum_q, Ovfl_q, Ovfl_sticky} !== 6'b0) begin
            errors++;
            $display("FAIL reset_regs: got Sum_q=%h Ovfl_q=%b sticky=%b, want 0 0 0", Sum_q, Ovfl_q, Ovfl_sticky);
        end
    endtask

    task automatic test_directed();
        logic [13:0] vecs [0:8];
        vecs = '{
            {4'h3, 4'h4, 1'b0, 4'h7, 1'b0},
            {4'hF, 4'hE, 1'b0, 4'hD, 1'b0},
            {4'h7, 4'h1, 1'b0, 4'h8, 1'b1},
            {4'h8, 4'hF, 1'b0, 4'h7, 1'b1},
            {4'h5, 4'h3, 1'b1, 4'h2, 1'b0},
            {4'h0, 4'h1, 1'b1, 4'hF, 1'b0},
            {4'h8, 4'h1, 1'b1, 4'h7, 1'b1},
            {4'h0, 4'h8, 1'b1, 4'h8, 1'b1},
            {4'hF, 4'h8, 1'b1, 4'h7, 1'b0}
        };
        for (int i = 0; i < 9; i++) begin
            A = vecs[i][13:10]; B = vecs[i][9:6]; sub = vecs[i][5];
            #1;
            checks++;
            if ({Sum, Ovfl} !== vecs[i][4:0]) begin
                errors++;
                $display("FAIL directed[%0d] A=%h B=%h sub=%b: got Sum=%h Ovfl=%b, want Sum=%h Ovfl=%b",
                         i, A, B, sub, Sum, Ovfl, vecs[i][4:1], vecs[i][0]);
            end
        end
    endtask

    // Exhaustive sweep; rst held high to show the comb path ignores it
    task automatic test_exhaustive();
        int bad;
        bad = 0;
        rst = 1'b1;
        for (int k = 0; k < 512; k++) begin
            A = 4'(k >> 5); B = 4'(k >> 1); sub = 1'(k);
            #1;
            checks++;
            if (Sum !== ref_sum(A, B, sub) || Ovfl !== ref_ovfl(A, B, sub)) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL exhaustive A=%h B=%h sub=%b: got Sum=%h Ovfl=%b, want Sum=%h Ovfl=%b",
                             A, B, sub, Sum, Ovfl, ref_sum(A, B, sub), ref_ovfl(A, B, sub));
            end
        end
    endtask

    task automatic test_sub_toggle();
        A = 4'h0; B = 4'h8; sub = 1'b0;
        #1;
        checks++;
        if ({Sum, Ovfl} !== {4'h8, 1'b0}) begin
            errors++;
            $display("FAIL toggle_add: got Sum=%h Ovfl=%b, want 8 0", Sum, Ovfl);
        end
        sub = 1'b1;
        #1;
        checks++;
        if ({Sum, Ovfl} !== {4'h8, 1'b1}) begin
            errors++;
            $display("FAIL toggle_sub: got Sum=%h Ovfl=%b, want 8 1", Sum, Ovfl);
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; A = 4'h7; B = 4'h1; sub = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({Sum_q, Ovfl_q, Ovfl_sticky} !== {4'h8, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reg_overflow: got Sum_q=%h Ovfl_q=%b sticky=%b, want 8 1 1", Sum_q, Ovfl_q, Ovfl_sticky);
        end
        @(negedge clk);
        A = 4'h1; B = 4'h1;
        @(posedge clk);
        #1;
        checks++;
        if ({Sum_q, Ovfl_q, Ovfl_sticky} !== {4'h2, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reg_sticky_hold: got Sum_q=%h Ovfl_q=%b sticky=%b, want 2 0 1", Sum_q, Ovfl_q, Ovfl_sticky);
        end
    endtask

    task automatic test_reset_overflow();
        @(negedge clk);
        rst = 1'b1; A = 4'h7; B = 4'h1; sub = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({Sum_q, Ovfl_q, Ovfl_sticky, Sum, Ovfl} !== {4'h0, 1'b0, 1'b0, 4'h8, 1'b1}) begin
            errors++;
            $display("FAIL reset_vs_ovfl: got Sum_q=%h Ovfl_q=%b sticky=%b Sum=%h Ovfl=%b, want 0 0 0 8 1",
                     Sum_q, Ovfl_q, Ovfl_sticky, Sum, Ovfl);
        end
    endtask

    // Randomized back-to-back cycles with occasional reset, against the model
    task automatic test_random();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        m_sum_q = 4'h0; m_ovfl_q = 1'b0; m_sticky = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            A   = 4'($urandom_range(0, 15));
            B   = 4'($urandom_range(0, 15));
            sub = 1'($urandom_range(0, 1));
            // bias toward long runs so sticky gets a chance to hold
            rst = ($urandom_range(0, 39) == 0);
            #1;
            checks++;
            if (Sum !== ref_sum(A, B, sub) || Ovfl !== ref_ovfl(A, B, sub)) begin
                errors++;
                $display("FAIL rand_comb[%0d] A=%h B=%h sub=%b: got Sum=%h Ovfl=%b, want Sum=%h Ovfl=%b",
                         n, A, B, sub, Sum, Ovfl, ref_sum(A, B, sub), ref_ovfl(A, B, sub));
            end
            if (rst) begin
                m_sum_q = 4'h0; m_ovfl_q = 1'b0; m_sticky = 1'b0;
            end else begin
                m_sum_q  = ref_sum(A, B, sub);
                m_ovfl_q = ref_ovfl(A, B, sub);
                m_sticky = m_sticky | m_ovfl_q;
            end
            @(posedge clk);
            #1;
            checks++;
            if ({Sum_q, Ovfl_q, Ovfl_sticky} !== {m_sum_q, m_ovfl_q, m_sticky}) begin
                errors++;
                $display("FAIL rand_reg[%0d]: got Sum_q=%h Ovfl_q=%b sticky=%b, want %h %b %b",
                         n, Sum_q, Ovfl_q, Ovfl_sticky, m_sum_q, m_ovfl_q, m_sticky);
            end
        end
    endtask

    initial begin
        rst = 1'b1; A = 4'h0; B = 4'h0; sub = 1'b0;
        test_reset();
        test_directed();
        test_sub_toggle();
        test_exhaustive();
        test_registered();
        test_reset_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
